// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a req/ack data bus, steers store lanes,
// extends load data and stalls the pipeline until the bus completes.
module mem_stage_lsu (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignM,
  output logic        StallM,
  output logic        MisalignedM,
  output logic [31:0] ReadDataM,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusWStrb,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state, stateNext;
  logic        misaligned, memOp, access;
  logic [31:0] wdLanes;
  logic [3:0]  strb;
  logic [1:0]  offR, sizeR;
  logic        signR;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadExt;

  always_comb begin
    memOp      = MemReadM | MemWriteM;
    misaligned = ((MemSizeM == 2'b01) & ALUResultM[0]) |
                 (MemSizeM[1] & (ALUResultM[1:0] != 2'b00));
    access     = memOp & ~misaligned;
  end

  always_comb begin
    wdLanes = WriteDataM;
    strb    = 4'b1111;
    unique case (MemSizeM)
      2'b00: begin
        wdLanes = {4{WriteDataM[7:0]}};
        strb    = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        wdLanes = {2{WriteDataM[15:0]}};
        strb    = 4'b0011 << {ALUResultM[1], 1'b0};
      end
      default: begin
        wdLanes = WriteDataM;
        strb    = 4'b1111;
      end
    endcase
  end

  // Extraction uses the attributes latched at launch, not the live M-stage inputs.
  always_comb begin
    byteSel = BusRData[{offR, 3'b000} +: 8];
    halfSel = BusRData[{offR[1], 4'b0000} +: 16];
    loadExt = BusRData;
    unique case (sizeR)
      2'b00:   loadExt = signR ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
      2'b01:   loadExt = signR ? {16'h0000, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: loadExt = BusRData;
    endcase
  end

  always_comb begin
    stateNext   = state;
    StallM      = 1'b0;
    MisalignedM = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          StallM    = 1'b1;
          stateNext = REQ;
        end else if (memOp & misaligned) begin
          MisalignedM = 1'b1;
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (BusAck) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BusReq    <= 1'b0;
      BusWe     <= 1'b0;
      BusAddr   <= '0;
      BusWData  <= '0;
      BusWStrb  <= '0;
      ReadDataM <= '0;
      offR      <= '0;
      sizeR     <= '0;
      signR     <= 1'b0;
    end else if ((state == IDLE) && access) begin
      BusReq   <= 1'b1;
      BusWe    <= MemWriteM;
      BusAddr  <= {ALUResultM[31:2], 2'b00};
      BusWData <= wdLanes;
      BusWStrb <= MemWriteM ? strb : 4'b0000;
      offR     <= ALUResultM[1:0];
      sizeR    <= MemSizeM;
      signR    <= MemSignM;
    end else if ((state == REQ) && BusAck) begin
      BusReq <= 1'b0;
      if (!BusWe) ReadDataM <= loadExt;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu with a transaction-level
// reference model and a per-cycle compare process.
module tb_mem_stage_lsu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        MemReadM, MemWriteM, MemSignM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [1:0]  MemSizeM;
  logic        StallM, MisalignedM;
  logic [31:0] ReadDataM;
  logic        BusReq, BusWe;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusWStrb;
  logic        BusAck;
  logic [31:0] BusRData;

  mem_stage_lsu dut (
    .CLK(CLK), .RST_N(RST_N), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemSizeM(MemSizeM),
    .MemSignM(MemSignM), .StallM(StallM), .MisalignedM(MisalignedM),
    .ReadDataM(ReadDataM), .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr),
    .BusWData(BusWData), .BusWStrb(BusWStrb), .BusAck(BusAck), .BusRData(BusRData)
  );

  always #5 CLK = ~CLK;

  int unsigned nVec = 0, nMiss = 0;
  logic        chkEn = 1'b0;

  // Expected values for the current cycle, set by the stimulus task
  logic        expStall = 1'b0, expMis = 1'b0, expReq = 1'b0, chkBus = 1'b0;
  logic        expWe = 1'b0;
  logic [31:0] expAddr = '0, expWData = '0, expRead = '0;
  logic [3:0]  expStrb = '0;
  logic [31:0] mdlRead = '0;

  // Per-operation observations used by the literal checks
  int unsigned stallCnt, reqCnt, misCnt;
  logic        addrStable;
  logic [31:0] capAddr, capWData;
  logic [3:0]  capStrb;
  logic        capWe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chkEn) begin
      chk("StallM", StallM, expStall);
      chk("MisalignedM", MisalignedM, expMis);
      chk("BusReq", BusReq, expReq);
      chk("ReadDataM", ReadDataM, expRead);
      if (chkBus) begin
        chk("BusWe", BusWe, expWe);
        chk("BusAddr", BusAddr, expAddr);
        chk("BusWStrb", BusWStrb, expStrb);
        if (expWe) chk("BusWData", BusWData, expWData);
      end
    end
  end

  function automatic int unsigned sizeBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Load result: take nb bytes starting at byte offset, then extend arithmetically
  function automatic logic [31:0] mdlLoad(input logic [31:0] rdata, input int unsigned off,
                                          input int unsigned nb, input logic zext);
    logic [31:0] sh;
    longint      v;
    sh = rdata >> (8 * off);
    v  = longint'(sh) % (longint'(1) << (8 * nb));
    if (nb < 4 && !zext && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic sampleCycle();
    @(negedge CLK);
    if (StallM) stallCnt++;
    if (MisalignedM) misCnt++;
    if (BusReq) begin
      if (reqCnt > 0 && BusAddr !== capAddr) addrStable = 1'b0;
      reqCnt++;
      capAddr  = BusAddr;
      capWData = BusWData;
      capStrb  = BusWStrb;
      capWe    = BusWe;
    end
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; presents one M-stage instruction until the pipeline advances
  task automatic runOp(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz, input logic sgn,
                       input int unsigned waits, input logic [31:0] rdata);
    int unsigned nb, off;
    logic        mis, acc;
    nb  = sizeBytes(sz);
    off = addr % 4;
    mis = (addr % nb) != 0;
    acc = (rd || wr) && !mis;
    MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wd;
    MemSizeM = sz; MemSignM = sgn;
    BusAck = 1'($urandom); BusRData = $urandom;
    stallCnt = 0; reqCnt = 0; misCnt = 0; addrStable = 1'b1;
    expStall = acc; expMis = (rd || wr) && mis; expReq = 1'b0; chkBus = 1'b0;
    expRead = mdlRead;
    sampleCycle();
    if (acc) begin
      expWe   = wr;
      expAddr = addr - off;
      expStrb = '0;
      for (int i = 0; i < 4; i++) begin
        if (wr && i >= int'(off) && i < int'(off + nb)) expStrb[i] = 1'b1;
        expWData[8*i +: 8] = wd[8*(i % int'(nb)) +: 8];
      end
      for (int unsigned k = 0; k <= waits; k++) begin
        expStall = 1'b1; expMis = 1'b0; expReq = 1'b1; chkBus = 1'b1;
        BusAck   = (k == waits);
        BusRData = (k == waits) ? rdata : $urandom;
        sampleCycle();
      end
      if (rd) mdlRead = mdlLoad(rdata, off, nb, sgn);
      expStall = 1'b0; expReq = 1'b0; chkBus = 1'b0; expRead = mdlRead;
      BusAck = 1'($urandom); BusRData = $urandom;
      sampleCycle();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
    MemSizeM = '0; MemSignM = 1'b0; BusAck = 1'b0; BusRData = '0;
    #3;
    chk("rst_BusReq", BusReq, 0);
    chk("rst_BusWe", BusWe, 0);
    chk("rst_BusAddr", BusAddr, 0);
    chk("rst_BusWData", BusWData, 0);
    chk("rst_BusWStrb", BusWStrb, 0);
    chk("rst_ReadDataM", ReadDataM, 0);
    chk("rst_StallM", StallM, 0);
    chk("rst_MisalignedM", MisalignedM, 0);
    #10 RST_N = 1'b1;
    @(posedge CLK); #1;
    chkEn = 1'b1;

    runOp(1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 2'b10, 1'b0, 0, 32'h0);
    chk("wst_addr", capAddr, 32'h104);
    chk("wst_strb", capStrb, 4'b1111);
    chk("wst_we", capWe, 1);
    chk("wst_stall_cycles", stallCnt, 2);
    runOp(1'b0, 1'b1, 32'h203, 32'h000000A5, 2'b00, 1'b0, 1, 32'h0);
    chk("bst_addr", capAddr, 32'h200);
    chk("bst_wdata", capWData, 32'hA5A5A5A5);
    chk("bst_strb", capStrb, 4'b1000);
    runOp(1'b1, 1'b0, 32'h1002, 32'h0, 2'b00, 1'b0, 0, 32'h80FF7F01);
    chk("lb_signed", ReadDataM, 32'hFFFFFFFF);
    runOp(1'b1, 1'b0, 32'h1002, 32'h0, 2'b00, 1'b1, 0, 32'h80FF7F01);
    chk("lbu", ReadDataM, 32'h000000FF);
    runOp(1'b1, 1'b0, 32'h1002, 32'h0, 2'b01, 1'b0, 0, 32'h80FF7F01);
    chk("lh_signed", ReadDataM, 32'hFFFF80FF);
    runOp(1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 1'b1, 3, 32'h12345678);
    chk("wait_req_cycles", reqCnt, 4);
    chk("wait_addr_stable", addrStable, 1);
    chk("wait_stall_cycles", stallCnt, 5);
    chk("wait_lw", ReadDataM, 32'h12345678);
    runOp(1'b0, 1'b1, 32'h401, 32'h5555AAAA, 2'b01, 1'b0, 0, 32'h0);
    chk("mis_half_flag", misCnt, 1);
    chk("mis_half_req", reqCnt, 0);
    chk("mis_half_stall", stallCnt, 0);
    runOp(1'b1, 1'b0, 32'h402, 32'h0, 2'b10, 1'b0, 0, 32'h0);
    chk("mis_word_flag", misCnt, 1);
    chk("mis_word_req", reqCnt, 0);
    chk("mis_word_read", ReadDataM, 32'h12345678);

    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 2);
      runOp(kind == 1, kind == 2, $urandom, $urandom, 2'($urandom_range(0, 3)),
            1'($urandom), $urandom_range(0, 3), $urandom);
    end

    // Reset during an outstanding load
    chkEn = 1'b0;
    MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h40; MemSizeM = 2'b10;
    BusAck = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("pre_rst_req", BusReq, 1);
    RST_N = 1'b0;
    #1;
    chk("midrst_BusReq", BusReq, 0);
    chk("midrst_ReadDataM", ReadDataM, 0);
    MemReadM = 1'b0;
    #1;
    chk("midrst_StallM", StallM, 0);
    @(posedge CLK); #3;
    RST_N = 1'b1;
    BusAck = 1'b1; BusRData = 32'hFFFFFFFF;
    repeat (3) @(posedge CLK);
    #1;
    chk("late_ack_ReadDataM", ReadDataM, 0);
    chk("late_ack_BusReq", BusReq, 0);
    chk("late_ack_StallM", StallM, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
